// File: rtl/reg_arb_pkg.sv
// Shared definitions for the register write arbiter.
// Latency: n/a (types and defaults only).
// Backpressure: n/a.
//
// Holds the FSM state encoding and the default WIDTH/NREQ values used by
// the interface, the storage register and the arbiter top.

package reg_arb_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREQ  = 4;

  // Arbiter FSM states; the encoding is fixed so software/debug views of the
  // state bits stay stable across revisions.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } state_t;

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Bundle of requester-side signals for the register write arbiter.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req/wdata until their ack pulse.
//
// Signals:
//   clr   - synchronous clear of the stored value (honoured only in IDLE)
//   req   - per-requester level-sensitive write request
//   wdata - packed write data, requester i owns [i*WIDTH +: WIDTH]
//   grant - registered one-hot grant
//   ack   - registered one-hot, one-cycle write-complete pulse
//   busy  - arbiter is not IDLE
//   q     - current stored register value

interface reg_write_arbiter_if
  import reg_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ
);

  logic                  clr;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       ack;
  logic                  busy;
  logic [WIDTH-1:0]      q;

  // Requester side drives requests and data.
  modport master (
    output clr,
    output req,
    output wdata,
    input  grant,
    input  ack,
    input  busy,
    input  q
  );

  // Arbiter side.
  modport slave (
    input  clr,
    input  req,
    input  wdata,
    output grant,
    output ack,
    output busy,
    output q
  );

endinterface

// File: rtl/register_nbit.sv
// Loadable WIDTH-bit storage register.
// Latency: q follows d one edge after load is sampled high.
// Backpressure: none; load is a plain enable.
//
// Ports:
//   clk   - rising-edge clock
//   load  - capture d on the next edge
//   reset - asynchronous active-low clear to 0
//   d     - next value
//   q     - stored value

module register_nbit
  import reg_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             load,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting NREQ requesters write access to one register.
// Latency: grant 1 edge after req is seen in IDLE, q/ack 2 edges after.
// Backpressure: one write per 3 cycles; losers simply keep req held.
//
// Ports:
//   clk   - sole clock, rising edge
//   reset - asynchronous active-low reset
//   bus   - slave side of reg_write_arbiter_if (clr, req, wdata, grant,
//           ack, busy, q)

module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ
) (
  input  logic                 clk,
  input  logic                 reset,
  reg_write_arbiter_if.slave   bus
);

  localparam int PTR_W = $clog2(NREQ);

  // FSM state and registered outputs
  state_t            r_state;
  state_t            w_state_nxt;
  logic [PTR_W-1:0]  r_ptr;
  logic [PTR_W-1:0]  w_ptr_nxt;
  logic [PTR_W-1:0]  r_idx;
  logic [PTR_W-1:0]  w_idx_nxt;
  logic [NREQ-1:0]   r_grant;
  logic [NREQ-1:0]   w_grant_nxt;
  logic [NREQ-1:0]   r_ack;
  logic [NREQ-1:0]   w_ack_nxt;

  // Storage register control
  logic              w_load;
  logic [WIDTH-1:0]  w_d;
  logic [WIDTH-1:0]  w_q;

  // Priority mux
  logic [WIDTH-1:0]  w_slices [NREQ];
  logic [PTR_W-1:0]  w_cand   [NREQ];
  logic              w_found;
  logic [PTR_W-1:0]  w_sel;
  logic [NREQ-1:0]   w_sel_oh;
  logic [NREQ-1:0]   w_idx_oh;
  logic [PTR_W-1:0]  w_ptr_inc;

  // Unpack the flat write-data bus so the winner's slice is a plain index.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      w_slices[i] = bus.wdata[i*WIDTH +: WIDTH];
    end
  end

  // Search order starts at the pointer and wraps modulo NREQ, so the
  // requester after the last writer has top priority.
  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      int c;
      c = int'(r_ptr) + k;
      if (c >= NREQ) begin
        c = c - NREQ;
      end
      w_cand[k] = PTR_W'(c);
    end
  end

  always_comb begin
    w_found = 1'b0;
    w_sel   = r_ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && bus.req[w_cand[k]]) begin
        w_found = 1'b1;
        w_sel   = w_cand[k];
      end
    end
  end

  always_comb begin
    w_sel_oh        = '0;
    w_sel_oh[w_sel] = 1'b1;
    w_idx_oh        = '0;
    w_idx_oh[r_idx] = 1'b1;
  end

  assign w_ptr_inc = (r_idx == PTR_W'(NREQ - 1)) ? '0 : r_idx + 1'b1;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_grant <= '0;
      r_ack   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_idx   <= w_idx_nxt;
      r_grant <= w_grant_nxt;
      r_ack   <= w_ack_nxt;
    end
  end

  // Next-state and output decode. grant/ack default low so each is a
  // single-cycle registered pulse; they can never overlap because they are
  // produced in different states.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_idx_nxt   = r_idx;
    w_grant_nxt = '0;
    w_ack_nxt   = '0;
    w_load      = 1'b0;
    w_d         = w_slices[r_idx];

    case (r_state)
      IDLE: begin
        // clr wins over requests; arbitration waits for the next cycle.
        if (bus.clr) begin
          w_load = 1'b1;
          w_d    = '0;
        end else if (w_found) begin
          w_idx_nxt   = w_sel;
          w_grant_nxt = w_sel_oh;
          w_state_nxt = GRANT;
        end
      end

      GRANT: begin
        // A requester that let go of req during GRANT forfeits the write;
        // ptr is left alone so it keeps its place in the rotation.
        if (bus.req[r_idx]) begin
          w_load      = 1'b1;
          w_ack_nxt   = w_idx_oh;
          w_state_nxt = ACK;
        end else begin
          w_state_nxt = IDLE;
        end
      end

      ACK: begin
        w_ptr_nxt   = w_ptr_inc;
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  register_nbit #(
    .WIDTH (WIDTH)
  ) u_register_nbit (
    .clk   (clk),
    .load  (w_load),
    .reset (reset),
    .d     (w_d),
    .q     (w_q)
  );

  assign bus.grant = r_grant;
  assign bus.ack   = r_ack;
  assign bus.busy  = (r_state != IDLE);
  assign bus.q     = w_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboarded bench for reg_write_arbiter: directed scenarios then random
// traffic, compared cycle by cycle against a transaction-level model.
module tb_reg_write_arbiter;
  import reg_arb_pkg::*;

  localparam int W = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_write_arbiter_if #(.WIDTH(W), .NREQ(N)) bus ();

  reg_write_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [N-1:0] grant;
    logic [N-1:0] ack;
    logic         busy;
    logic [W-1:0] q;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  int   checks   = 0;
  int   failures = 0;

  // Reference model: a write "transaction" owned by m_owner, m_age edges old.
  int           m_ptr;
  int           m_owner;
  int           m_age;
  logic [W-1:0] m_q;

  task automatic model_reset();
    m_ptr   = 0;
    m_owner = -1;
    m_age   = 0;
    m_q     = '0;
  endtask

  // Inputs seen at the coming edge -> outputs expected after that edge.
  task automatic model_step(input logic c, input logic [N-1:0] r,
                            input logic [N*W-1:0] d);
    exp_t e;
    e = '0;
    if (m_owner < 0) begin
      if (c) begin
        m_q = '0;
      end else if (r != '0) begin
        for (int k = 0; k < N; k++)
          if (m_owner < 0 && r[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
        m_age = 1;
        e.grant[m_owner] = 1'b1;
      end
    end else if (m_age == 1) begin
      if (r[m_owner]) begin
        m_q = d[m_owner*W +: W];
        e.ack[m_owner] = 1'b1;
        m_age = 2;
      end else begin
        m_owner = -1;
      end
    end else begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
    end
    e.busy = (m_owner >= 0);
    e.q    = m_q;
    exp_q.push_back(e);
    last_exp = e;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  // Monitor: each negedge, the oldest expectation is compared to the DUT.
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {bus.grant, bus.ack, bus.busy, bus.q};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL cycle_cmp t=%0t got g=%b a=%b b=%b q=%h want g=%b a=%b b=%b q=%h",
                 $time, a.grant, a.ack, a.busy, a.q, e.grant, e.ack, e.busy, e.q);
      end
    end
  end

  // One clock of stimulus; optional async reset pulse mid-cycle first.
  task automatic step(input logic c, input logic [N-1:0] r,
                      input logic [N*W-1:0] d, input logic rst);
    @(negedge clk);
    #1;
    if (rst) begin
      reset = 1'b0;
      #1;
      chk("rst_async", {bus.grant, bus.ack, bus.busy, bus.q}, '0);
      model_reset();
      #1 reset = 1'b1;
    end
    bus.clr   = c;
    bus.req   = r;
    bus.wdata = d;
    model_step(c, r, d);
  endtask

  logic [N*W-1:0] dv;
  logic [N-1:0]   rq;
  int             ack_cyc[$];
  logic [W-1:0]   ack_qv[$];
  logic [N-1:0]   ack_v[$];

  initial begin
    reset     = 1'b0;
    bus.clr   = 1'b0;
    bus.req   = '0;
    bus.wdata = '0;
    model_reset();
    last_exp  = '0;
    #3;
    chk("rst_init", {bus.grant, bus.ack, bus.busy, bus.q}, '0);
    #1 reset = 1'b1;

    // Single write from requester 2
    dv = '0;
    dv[2*W +: W] = 8'hA5;
    step(1'b0, 4'b0100, dv, 1'b0);
    step(1'b0, 4'b0100, dv, 1'b0);
    chk("sw_grant", bus.grant, 4'b0100);
    step(1'b0, 4'b0000, dv, 1'b0);
    chk("sw_ack", bus.ack, 4'b0100);
    chk("sw_q", bus.q, 8'hA5);
    step(1'b0, 4'b0000, dv, 1'b0);
    chk("sw_busy", bus.busy, 1'b0);

    // Full contention from a fresh reset
    for (int i = 0; i < N; i++) dv[i*W +: W] = W'(8'h10 + i);
    step(1'b0, 4'b1111, dv, 1'b1);
    for (int t = 1; t <= 15; t++) begin
      step(1'b0, 4'b1111, dv, 1'b0);
      if (bus.ack != '0) begin
        ack_cyc.push_back(t);
        ack_qv.push_back(bus.q);
        ack_v.push_back(bus.ack);
      end
    end
    chk("cont_count", ack_qv.size(), 5);
    for (int k = 0; k < 5 && k < ack_qv.size(); k++) begin
      chk("cont_q", ack_qv[k], 8'h10 + (k % 4));
      chk("cont_ack", ack_v[k], 1 << (k % 4));
      if (k > 0) chk("cont_gap", ack_cyc[k] - ack_cyc[k-1], 3);
    end

    // Abort keeps ptr: requester 0 writes, requester 1 aborts, 1 still first
    dv = '0;
    dv[0*W +: W] = 8'h5A;
    dv[1*W +: W] = 8'hC3;
    step(1'b0, 4'b0001, dv, 1'b1);
    step(1'b0, 4'b0001, dv, 1'b0);
    step(1'b0, 4'b0000, dv, 1'b0);
    step(1'b0, 4'b0010, dv, 1'b0);
    step(1'b0, 4'b0000, dv, 1'b0);
    chk("ab_grant", bus.grant, 4'b0010);
    step(1'b0, 4'b0011, dv, 1'b0);
    chk("ab_noack", bus.ack, 4'b0000);
    chk("ab_q", bus.q, 8'h5A);
    step(1'b0, 4'b0011, dv, 1'b0);
    chk("ab_regrant", bus.grant, 4'b0010);

    // Clear in IDLE beats a pending request for one cycle
    dv = '0;
    dv[0*W +: W] = 8'h3C;
    step(1'b0, 4'b0001, dv, 1'b1);
    step(1'b0, 4'b0001, dv, 1'b0);
    step(1'b0, 4'b0000, dv, 1'b0);
    step(1'b1, 4'b0001, dv, 1'b0);
    chk("clr_before", bus.q, 8'h3C);
    step(1'b0, 4'b0001, dv, 1'b0);
    chk("clr_q", bus.q, 8'h00);
    chk("clr_nogrant", bus.grant, 4'b0000);
    step(1'b0, 4'b0001, dv, 1'b0);
    chk("clr_grant", bus.grant, 4'b0001);
    step(1'b0, 4'b0000, dv, 1'b0);

    // Reset while in GRANT, then requester 0 first
    step(1'b0, 4'b0001, dv, 1'b0);
    dv[3*W +: W] = 8'h99;
    step(1'b0, 4'b1001, dv, 1'b1);
    step(1'b0, 4'b1001, dv, 1'b0);
    chk("rstmid_grant", bus.grant, 4'b0001);

    // Wrap: after requester 2 writes, requester 0 beats requester 2
    dv = '0;
    dv[0*W +: W] = 8'h0F;
    dv[2*W +: W] = 8'h77;
    step(1'b0, 4'b0000, dv, 1'b1);
    step(1'b0, 4'b0100, dv, 1'b0);
    step(1'b0, 4'b0100, dv, 1'b0);
    step(1'b0, 4'b0000, dv, 1'b0);
    ack_v.delete();
    ack_qv.delete();
    for (int t = 0; t < 6; t++) begin
      step(1'b0, 4'b0101, dv, 1'b0);
      if (bus.ack != '0) begin
        ack_v.push_back(bus.ack);
        ack_qv.push_back(bus.q);
      end
    end
    chk("wrap_count", ack_v.size(), 2);
    if (ack_v.size() >= 2) begin
      chk("wrap_first", ack_v[0], 4'b0001);
      chk("wrap_first_q", ack_qv[0], 8'h0F);
      chk("wrap_second", ack_v[1], 4'b0100);
    end

    // Random traffic: requesters hold until ack, occasionally abort in
    // GRANT; random clr (any state) and rare mid-operation resets.
    rq = '0;
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N; i++) begin
        if (rq[i] && last_exp.ack[i]) begin
          rq[i] = 1'b0;
        end else if (rq[i] && last_exp.grant[i] && $urandom_range(0, 5) == 0) begin
          rq[i] = 1'b0;
        end else if (!rq[i] && $urandom_range(0, 3) == 0) begin
          rq[i] = 1'b1;
          dv[i*W +: W] = W'($urandom);
        end
      end
      step($urandom_range(0, 7) == 0, rq, dv,
           (t == 0) || ($urandom_range(0, 60) == 0));
    end

    repeat (2) @(negedge clk);
    #1;
    chk("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
